ramp_sequencer: RTL
===================

RAMP_SEQUENCER -- requirements
Module: ramp_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DW, 8, data width of the counter value, start value and target.
- PW, 8, width of the step prescaler.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all state changes on its rising edge.
- clear  in  1  reset; synchronous, active-high.
- enable  in  1  level request to ramp up (1) or ramp down and shut off (0).
- start_val  in  DW  value preloaded into the counter at ramp start.
- target  in  DW  final ramp value.
- step_div  in  PW  number of clocks per counter step, minus 1.
- cnt_q  in  DW  current counter output (feedback).
- cnt_d  out  DW  counter load data.
- cnt_clear_n  out  1  active-low counter clear.
- cnt_load  out  1  counter load strobe.
- cnt_up_down  out  1  counter direction (1 = up, 0 = down).
- busy  out  1  high in any state other than IDLE.
- pgood  out  1  high only in HOLD.
- cfg_err  out  1  sticky flag: start_val > target was seen at start.

Function
REQ-003 The block SHALL implement the states IDLE, PRELOAD, RAMP_UP, HOLD and RAMP_DN, held in a registered state variable.

REQ-004 In IDLE the block SHALL drive cnt_clear_n=0, cnt_load=0, cnt_up_down=0 and cnt_d=0.

REQ-005 In every state other than IDLE the block SHALL drive cnt_clear_n=1.

REQ-006 IDLE -> PRELOAD SHALL occur when enable=1, start_val <= target and cfg_err=0.

REQ-007 When in IDLE with enable=1 and start_val > target, the block SHALL set cfg_err=1 and remain in IDLE.

REQ-008 cfg_err SHALL clear only on the first cycle of IDLE with enable=0, or on reset.

REQ-009 On the IDLE -> PRELOAD edge the block SHALL latch target and step_div into internal registers.
- All later comparisons use the latched values.
- Input changes during the ramp are ignored.

REQ-010 PRELOAD SHALL last exactly one cycle.
- Outputs: cnt_load=1, cnt_d=start_val.
- Next state: RAMP_UP, unconditionally.

REQ-011 The prescaler SHALL work as follows.
- It is PW bits wide and resets to 0 on every state transition.
- In RAMP_UP and RAMP_DN it increments each cycle.
- A tick is asserted when it equals the latched step_div; the prescaler wraps to 0 on that same cycle.

REQ-012 In RAMP_UP and RAMP_DN, on non-tick cycles the block SHALL hold the counter: cnt_load=1, cnt_d=cnt_q.

REQ-013 In RAMP_UP, on a tick with cnt_q < latched target, the block SHALL drive cnt_load=0 and cnt_up_down=1 (increment by one).

REQ-014 RAMP_UP -> HOLD SHALL occur when cnt_q == latched target.
- That cycle drives hold outputs; no increment is issued.
- This check takes priority over the tick.
- If start_val == target, HOLD follows RAMP_UP one cycle after PRELOAD.

REQ-015 In HOLD the block SHALL drive cnt_load=1 and cnt_d=cnt_q, with pgood=1.

REQ-016 RAMP_UP -> RAMP_DN and HOLD -> RAMP_DN SHALL occur when enable=0, with priority over the REQ-014 check.

REQ-017 In RAMP_DN, on a tick with cnt_q != 0, the block SHALL drive cnt_load=0 and cnt_up_down=0 (decrement by one).

REQ-018 RAMP_DN -> IDLE SHALL occur when cnt_q == 0.

REQ-019 RAMP_DN -> RAMP_UP SHALL occur when enable=1 and cnt_q != 0.
- There is no preload; the ramp resumes from the current value with the latched target.
- When enable=1 and cnt_q == 0 at the same time, RAMP_DN -> IDLE wins; re-entry then follows REQ-006.

REQ-020 Counter-control outputs SHALL be combinational from state, prescaler and cnt_q; busy and pgood SHALL be decoded from state.

REQ-021 One counter step SHALL occur per (latched step_div + 1) clocks; step_div=0 gives one step per clock.

REQ-022 All DW-bit comparisons SHALL be unsigned.
- The block never commands an increment at the latched target or a decrement at 0.
- Counter wrap-around is therefore impossible.

Reset
REQ-023 When clear=1 at a rising clk edge, the block SHALL set state=IDLE, prescaler=0, latched target=0, latched step_div=0 and cfg_err=0.
- This applies from any state, including mid-ramp.

REQ-024 During and after reset, outputs SHALL be cnt_clear_n=0, cnt_load=0, cnt_up_down=0, cnt_d=0, busy=0 and pgood=0.
- The counter is therefore cleared on the following edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic ramp: start_val=0x10, target=0x14, step_div=2, enable=1 -> PRELOAD loads 0x10; one increment every 3 clocks; cnt_q reaches 0x14; pgood=1 and no further increments.
- Shutdown: from HOLD at 0x14 with step_div=2, drop enable -> pgood=0 the next cycle; decrement every 3 clocks to 0x00; IDLE; busy=0; cnt_clear_n=0.
- Abort mid-ramp: step_div=0, start 0x00, target 0xFF; drop enable when cnt_q=0x40 -> RAMP_DN; reassert enable at cnt_q=0x3C -> RAMP_UP resumes from 0x3C with no reload to 0x00.
- Config error: start_val=0x20, target=0x10, enable=1 -> cfg_err=1, busy=0; cfg_err clears after enable=0; a valid config then starts normally.
- Equal bounds and input change: start_val=target=0x55 -> HOLD two cycles after leaving IDLE; changing target mid-HOLD has no effect.
- Reset mid-ramp: assert clear in RAMP_UP at cnt_q=0x30 -> next cycle IDLE, all outputs at reset values; counter reads 0x00 one edge later.

Source files
------------

// File: rtl/ramp_sequencer.sv
// Ramp sequencer: drives an external up/down counter from a start value to a target,
// holds there while enabled, and ramps back to zero when enable drops.
module ramp_sequencer #(
    parameter int DW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    input  logic [DW-1:0] start_val,
    input  logic [DW-1:0] target,
    input  logic [PW-1:0] step_div,
    input  logic [DW-1:0] cnt_q,
    output logic [DW-1:0] cnt_d,
    output logic          cnt_clear_n,
    output logic          cnt_load,
    output logic          cnt_up_down,
    output logic          busy,
    output logic          pgood,
    output logic          cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        RAMP_UP,
        HOLD,
        RAMP_DN
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [PW-1:0] div_q;
    logic [DW-1:0] tgt_q;

    logic tick;
    logic at_top;
    logic at_zero;

    assign tick    = (presc == div_q);
    assign at_top  = (cnt_q == tgt_q);
    assign at_zero = (cnt_q == '0);

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            presc   <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (enable) begin
                        if (start_val > target) begin
                            cfg_err <= 1'b1;
                        end else if (!cfg_err) begin
                            state <= PRELOAD;
                            tgt_q <= target;
                            div_q <= step_div;
                        end
                    end else begin
                        cfg_err <= 1'b0;
                    end
                end
                PRELOAD: begin
                    state <= RAMP_UP;
                    presc <= '0;
                end
                RAMP_UP: begin
                    // Shutdown request outranks reaching the target.
                    if (!enable) begin
                        state <= RAMP_DN;
                        presc <= '0;
                    end else if (at_top) begin
                        state <= HOLD;
                        presc <= '0;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                    end
                end
                HOLD: begin
                    presc <= '0;
                    if (!enable) state <= RAMP_DN;
                end
                RAMP_DN: begin
                    // Reaching zero outranks a resume request.
                    if (at_zero) begin
                        state <= IDLE;
                        presc <= '0;
                    end else if (enable) begin
                        state <= RAMP_UP;
                        presc <= '0;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        cnt_clear_n = 1'b1;
        cnt_load    = 1'b1;
        cnt_up_down = 1'b0;
        cnt_d       = cnt_q;
        case (state)
            IDLE: begin
                cnt_clear_n = 1'b0;
                cnt_load    = 1'b0;
                cnt_d       = '0;
            end
            PRELOAD: begin
                cnt_d = start_val;
            end
            RAMP_UP: begin
                if (!at_top && tick) begin
                    cnt_load    = 1'b0;
                    cnt_up_down = 1'b1;
                end
            end
            RAMP_DN: begin
                if (!at_zero && tick) cnt_load = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign pgood = (state == HOLD);

endmodule
